// File: rtl/neuro_wb_pkg.sv
// Shared definitions for the neuro_wb_master Wishbone initiator.
// Holds the FSM state type, the default bus geometry and timeout, and
// the base address of the Neuromorphic_X1_wb slave window.
package neuro_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] NEURO_WB_BASE    = 32'h3000_0000;
  localparam int          NEURO_WB_AW      = 32;
  localparam int          NEURO_WB_DW      = 32;
  localparam int          NEURO_WB_TIMEOUT = 1024;

endpackage

// File: rtl/neuro_wb_timeout.sv
// Stall timer for a pending Wishbone strobe.
// Ports:
//   wb_clk_i, wb_rst_n : clock, asynchronous active-low reset
//   clr                : restart the count at zero (command accepted)
//   en                 : count this cycle (strobe outstanding)
//   expired            : current cycle is the TIMEOUT-th strobe cycle
// TIMEOUT = 0 disables the timer; expired then stays low.
module neuro_wb_timeout
  import neuro_wb_pkg::*;
#(
  parameter int TIMEOUT = NEURO_WB_TIMEOUT,
  parameter int TW      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1)
) (
  input  logic wb_clk_i,
  input  logic wb_rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TW-1:0] LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clr) begin
      timer_d = '0;
    end else if (en) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // The first strobe cycle sees timer 0, so LAST marks strobe cycle TIMEOUT.
  assign expired = (TIMEOUT != 0) && (timer_q == LAST);

endmodule

// File: rtl/neuro_wb_master.sv
// Wishbone classic-cycle initiator driving the Neuromorphic_X1_wb slave.
// Accepts one command at a time on cmd_*, runs a single read or write on
// wbm_*, and returns read data or a timeout error on rsp_*.
// Ports:
//   wb_clk_i, wb_rst_n      : clock, asynchronous active-low reset
//   cmd_valid/ready, cmd_we, cmd_adr, cmd_dat, cmd_sel : command stream
//   rsp_valid/ready, rsp_dat, rsp_err                  : response stream
//   wbm_cyc_o .. wbm_sel_o, wbm_dat_i, wbm_ack_i       : Wishbone master
//   busy    : transfer or response in flight
//   txn_cnt : completed transfers (acked or timed out), wraps
//   err_cnt : timed-out transfers, saturates
module neuro_wb_master
  import neuro_wb_pkg::*;
#(
  parameter int AW      = NEURO_WB_AW,
  parameter int DW      = NEURO_WB_DW,
  parameter int TIMEOUT = NEURO_WB_TIMEOUT,
  parameter int CNTW    = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW-1:0]   cmd_dat,
  input  logic [DW/8-1:0] cmd_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  output logic            busy,
  output logic [CNTW-1:0] txn_cnt,
  output logic [CNTW-1:0] err_cnt
);

  state_e            state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic [DW/8-1:0]   sel_q, sel_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_dat_q, rsp_dat_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNTW-1:0]   txn_cnt_q, txn_cnt_d;
  logic [CNTW-1:0]   err_cnt_q, err_cnt_d;

  logic              cmd_fire;
  logic              expired;

  assign cmd_fire = (state_q == IDLE) && cmd_valid;

  neuro_wb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .wb_clk_i (wb_clk_i),
    .wb_rst_n (wb_rst_n),
    .clr      (cmd_fire),
    .en       (state_q == REQ),
    .expired  (expired)
  );

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    txn_cnt_d   = txn_cnt_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // An ack in the expiry cycle takes priority over the timeout.
        if (wbm_ack_i) begin
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          txn_cnt_d   = txn_cnt_q + 1'b1;
          state_d     = RESP;
        end else if (expired) begin
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          txn_cnt_d   = txn_cnt_q + 1'b1;
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      txn_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      txn_cnt_q   <= txn_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign txn_cnt   = txn_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_neuro_wb_master.sv
// Bench for neuro_wb_master with a short timeout of 8 strobe cycles.
// A programmable slave acks after a chosen number of strobe cycles (or
// never); a transaction-level model predicts each response, the strobe
// length and the counters, and a negedge compare process checks the DUT.
module tb_neuro_wb_master;
  import neuro_wb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TMO  = 8;
  localparam int CNTW = 16;

  logic            wb_clk_i = 1'b0;
  logic            wb_rst_n = 1'b0;
  logic            cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0]   cmd_adr;
  logic [DW-1:0]   cmd_dat;
  logic [DW/8-1:0] cmd_sel;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0]   rsp_dat;
  logic            wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [AW-1:0]   wbm_adr_o;
  logic [DW-1:0]   wbm_dat_o;
  logic [DW/8-1:0] wbm_sel_o;
  logic [DW-1:0]   wbm_dat_i;
  logic            wbm_ack_i;
  logic            busy;
  logic [CNTW-1:0] txn_cnt, err_cnt;

  neuro_wb_master #(.AW(AW), .DW(DW), .TIMEOUT(TMO), .CNTW(CNTW)) dut (
    .wb_clk_i  (wb_clk_i),  .wb_rst_n  (wb_rst_n),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_we (cmd_we),
    .cmd_adr   (cmd_adr),   .cmd_dat   (cmd_dat),   .cmd_sel (cmd_sel),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),   .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o), .wbm_stb_o (wbm_stb_o), .wbm_we_o (wbm_we_o),
    .wbm_adr_o (wbm_adr_o), .wbm_dat_o (wbm_dat_o), .wbm_sel_o (wbm_sel_o),
    .wbm_dat_i (wbm_dat_i), .wbm_ack_i (wbm_ack_i),
    .busy      (busy),      .txn_cnt   (txn_cnt),   .err_cnt (err_cnt)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc_no = 0;

  always @(posedge wb_clk_i) cyc_no <= cyc_no + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Slave: acks when the strobe has been high for ack_delay earlier cycles;
  // ack_delay < 0 never acks. stray_ack drives ack regardless of strobe.
  int          ack_delay = 0;
  int          stb_age;
  logic        stray_ack = 1'b0;
  logic [31:0] rd_data = 32'h0;

  always @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n)      stb_age <= 0;
    else if (wbm_stb_o) stb_age <= stb_age + 1;
    else                stb_age <= 0;
  end

  assign wbm_ack_i = (wbm_stb_o && ack_delay >= 0 && stb_age == ack_delay) || stray_ack;
  assign wbm_dat_i = rd_data;

  // Transaction-level model.
  typedef struct {
    logic [31:0] dat;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_push, e_pop;
  logic        cur_valid = 1'b0;
  logic        cur_we;
  logic [31:0] cur_adr, cur_dat;
  logic [3:0]  cur_sel;
  int          cur_len = 0;
  int          stb_run = 0;
  int          last_stb_len = 0;
  int          n_done = 0;
  int          n_err = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] prev_dat;
  logic        prev_err;

  always @(negedge wb_clk_i) begin
    if (!wb_rst_n) begin
      chk("rst_cyc", wbm_cyc_o, 0);
      chk("rst_stb", wbm_stb_o, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_txn_cnt", txn_cnt, 0);
      chk("rst_err_cnt", err_cnt, 0);
      exp_q.delete();
      cur_valid = 1'b0;
      stb_run   = 0;
      n_done    = 0;
      n_err     = 0;
      hold_prev = 1'b0;
    end else begin
      chk("cyc_eq_stb", wbm_cyc_o, wbm_stb_o);
      chk("cmd_ready_vs_busy", cmd_ready, !busy);
      if (cur_valid) begin
        chk("wbm_we", wbm_we_o, cur_we);
        chk("wbm_adr", wbm_adr_o, cur_adr);
        chk("wbm_dat", wbm_dat_o, cur_dat);
        chk("wbm_sel", wbm_sel_o, cur_sel);
      end
      if (wbm_stb_o) begin
        stb_run++;
      end else if (stb_run != 0) begin
        chk("stb_len", stb_run, cur_len);
        last_stb_len = stb_run;
        stb_run = 0;
      end
      if (hold_prev) begin
        chk("rsp_hold_valid", rsp_valid, 1);
        chk("rsp_hold_dat", rsp_dat, prev_dat);
        chk("rsp_hold_err", rsp_err, prev_err);
      end
      hold_prev = rsp_valid && !rsp_ready;
      prev_dat  = rsp_dat;
      prev_err  = rsp_err;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          bound_fail("rsp_without_command");
        end else begin
          e_pop = exp_q.pop_front();
          n_done++;
          if (e_pop.err) n_err++;
          chk("rsp_dat", rsp_dat, e_pop.dat);
          chk("rsp_err", rsp_err, e_pop.err);
          chk("txn_cnt", txn_cnt, CNTW'(n_done));
          chk("err_cnt", err_cnt, CNTW'(n_err));
        end
      end
      if (cmd_valid && cmd_ready) begin
        e_push.err = (ack_delay < 0) || (ack_delay >= TMO);
        e_push.dat = (e_push.err || cmd_we) ? 32'h0 : rd_data;
        exp_q.push_back(e_push);
        cur_len   = e_push.err ? TMO : ack_delay + 1;
        cur_valid = 1'b1;
        cur_we    = cmd_we;
        cur_adr   = cmd_adr;
        cur_dat   = cmd_dat;
        cur_sel   = cmd_sel;
      end
    end
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic keep, output int hs);
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
    hs = -1;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready) hs = cyc_no;
      @(posedge wb_clk_i); #1;
      if (hs >= 0) break;
    end
    if (!keep) cmd_valid = 1'b0;
    if (hs < 0) bound_fail("cmd_accept");
  endtask

  task automatic wait_rsp(output int rv);
    rv = -1;
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid) begin
        rv = cyc_no;
        break;
      end
      @(posedge wb_clk_i); #1;
    end
    if (rv < 0) bound_fail("rsp_wait");
  endtask

  task automatic take_rsp(output logic [31:0] d, output logic er);
    d  = rsp_dat;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge wb_clk_i); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int          hs, rv, h;
    logic [31:0] d;
    logic        er;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    wb_rst_n = 1'b1;
    @(posedge wb_clk_i); #1;
    chk("idle_cmd_ready", cmd_ready, 1);

    // Write, ack in the third strobe cycle.
    ack_delay = 2; rd_data = 32'hA5A5_5A5A;
    do_cmd(1'b1, NEURO_WB_BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 1'b0, hs);
    wait_rsp(rv);
    take_rsp(d, er);
    chk("wr_stb_len", last_stb_len, 3);
    chk("wr_latency", rv - hs, 4);
    chk("wr_rsp_dat", d, 32'h0);
    chk("wr_rsp_err", er, 0);
    chk("wr_txn_cnt", txn_cnt, 1);

    // Read, combinational ack in the first strobe cycle.
    ack_delay = 0; rd_data = 32'h1234_5678;
    do_cmd(1'b0, NEURO_WB_BASE + 32'h8, 32'h0, 4'h3, 1'b0, hs);
    wait_rsp(rv);
    take_rsp(d, er);
    chk("rd_latency", rv - hs, 2);
    chk("rd_stb_len", last_stb_len, 1);
    chk("rd_rsp_dat", d, 32'h1234_5678);
    chk("rd_rsp_err", er, 0);

    // Timeout, slave never acks.
    ack_delay = -1; rd_data = 32'h7777_7777;
    do_cmd(1'b0, NEURO_WB_BASE + 32'hC, 32'h0, 4'hF, 1'b0, hs);
    wait_rsp(rv);
    take_rsp(d, er);
    chk("to_stb_len", last_stb_len, 8);
    chk("to_rsp_err", er, 1);
    chk("to_rsp_dat", d, 32'h0);
    chk("to_err_cnt", err_cnt, 1);
    chk("to_txn_cnt", txn_cnt, 3);

    // Ack in the last cycle before expiry: ack wins.
    ack_delay = 7; rd_data = 32'hCAFE_F00D;
    do_cmd(1'b0, NEURO_WB_BASE + 32'h10, 32'h0, 4'hF, 1'b0, hs);
    wait_rsp(rv);
    take_rsp(d, er);
    chk("ackto_stb_len", last_stb_len, 8);
    chk("ackto_rsp_err", er, 0);
    chk("ackto_rsp_dat", d, 32'hCAFE_F00D);
    chk("ackto_err_cnt", err_cnt, 1);

    // Stray ack while idle has no effect.
    stray_ack = 1'b1;
    repeat (3) begin
      @(posedge wb_clk_i); #1;
    end
    stray_ack = 1'b0;
    chk("stray_busy", busy, 0);
    chk("stray_txn_cnt", txn_cnt, 4);
    chk("stray_rsp_valid", rsp_valid, 0);

    // Response backpressure with a second command waiting.
    ack_delay = 1; rd_data = 32'h0BAD_F00D;
    do_cmd(1'b0, NEURO_WB_BASE + 32'h14, 32'h0, 4'hF, 1'b1, hs);
    cmd_we = 1'b1; cmd_adr = NEURO_WB_BASE + 32'h18; cmd_dat = 32'h55AA_55AA; cmd_sel = 4'hC;
    wait_rsp(rv);
    stray_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_dat", rsp_dat, 32'h0BAD_F00D);
      @(posedge wb_clk_i); #1;
    end
    stray_ack = 1'b0;
    chk("bp_txn_cnt", txn_cnt, 5);
    h = cyc_no;
    rsp_ready = 1'b1;
    @(posedge wb_clk_i); #1;
    rsp_ready = 1'b0;
    chk("bp_rsp_dropped", rsp_valid, 0);
    chk("bp_ready_after", cmd_ready, 1);
    @(posedge wb_clk_i); #1;
    cmd_valid = 1'b0;
    chk("bp_next_cycle", cyc_no - h, 2);
    chk("bp_next_stb", wbm_stb_o, 1);
    chk("bp_next_adr", wbm_adr_o, NEURO_WB_BASE + 32'h18);
    wait_rsp(rv);
    take_rsp(d, er);
    chk("bp2_rsp_dat", d, 32'h0);
    chk("bp2_txn_cnt", txn_cnt, 6);

    // Reset in the middle of a strobe.
    ack_delay = -1;
    do_cmd(1'b0, NEURO_WB_BASE + 32'h20, 32'h0, 4'hF, 1'b0, hs);
    @(posedge wb_clk_i); #1;
    chk("mr_stb_before", wbm_stb_o, 1);
    #2 wb_rst_n = 1'b0;
    #1;
    chk("mr_cyc", wbm_cyc_o, 0);
    chk("mr_stb", wbm_stb_o, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_n = 1'b1;
    @(posedge wb_clk_i); #1;
    chk("mr_cmd_ready", cmd_ready, 1);
    chk("mr_busy", busy, 0);
    chk("mr_txn_cnt", txn_cnt, 0);
    chk("mr_err_cnt", err_cnt, 0);

    // One transfer after reset counts from zero.
    ack_delay = 0; rd_data = 32'h0000_BEEF;
    do_cmd(1'b0, NEURO_WB_BASE, 32'h0, 4'h1, 1'b0, hs);
    wait_rsp(rv);
    take_rsp(d, er);
    chk("post_rsp_dat", d, 32'h0000_BEEF);
    chk("post_txn_cnt", txn_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/neuro_wb_master.md
Name: neuro_wb_master

Overview:
Wishbone classic-cycle initiator that drives the Neuromorphic_X1_wb slave port from an internal command/response stream, for example a logic-analyzer or IO-side test sequencer. It accepts one command at a time on a valid/ready interface and runs a single Wishbone read or write. It returns the read data, or an error status if the transfer times out, on a response valid/ready interface. The block sits in user_project_wrapper between the sequencer logic and the mprj Wishbone pins.

Parameters:
AW, 32, address width
DW, 32, data width (sel width = DW/8)
TIMEOUT, 1024, cycles stb may wait for ack before abort; 0 disables the timeout
CNTW, 16, width of transaction/error counters

Ports:
wb_clk_i  in  1  clock, the only clock in the block
wb_rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_we  in  1  1 = write, 0 = read
cmd_adr  in  AW  byte address
cmd_dat  in  DW  write data
cmd_sel  in  DW/8  byte selects
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_dat  out  DW  read data (0 for writes and errors)
rsp_err  out  1  transfer timed out
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  Wishbone write enable
wbm_adr_o  out  AW  Wishbone address
wbm_dat_o  out  DW  Wishbone write data
wbm_sel_o  out  DW/8  Wishbone byte selects
wbm_dat_i  in  DW  Wishbone read data
wbm_ack_i  in  1  Wishbone acknowledge
busy  out  1  state != IDLE
txn_cnt  out  CNTW  completed transfers, acked or timed out; wraps
err_cnt  out  CNTW  timed-out transfers; saturates at all-ones

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - state = IDLE.
  - All wbm_* outputs, rsp_* outputs, timer, txn_cnt and err_cnt are 0.
  - cyc and stb drop immediately on reset assertion, even mid-transfer.
- Registered outputs. FSM states are IDLE, REQ and RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch we/adr/dat/sel into the wbm_* registers, set cyc = stb = 1, clear the timer, go to REQ.
- REQ:
  - cmd_ready = 0. cyc, stb and all wbm_* outputs are held stable.
  - Timer increments every cycle.
  - If wbm_ack_i = 1:
    - Capture rsp_dat = wbm_dat_i for reads, 0 for writes; rsp_err = 0.
    - Drop cyc and stb, set rsp_valid = 1, increment txn_cnt, go to RESP.
  - Else if TIMEOUT != 0 and timer == TIMEOUT-1:
    - Drop cyc and stb; rsp_dat = 0; rsp_err = 1; rsp_valid = 1.
    - Increment txn_cnt and err_cnt; go to RESP.
  - If ack arrives in the timeout cycle, ack wins and no error is reported.
- RESP:
  - rsp_valid, rsp_dat and rsp_err are held until rsp_ready = 1.
  - On that handshake, rsp_valid = 0 and the next state is IDLE.
  - A new command can be accepted no earlier than the cycle after the handshake.
- Latency:
  - Command handshake at cycle N puts stb high at N+1.
  - Ack sampled at N+k puts rsp_valid high at N+k+1.
  - Minimum command-to-response time is 2 cycles.
- wbm_ack_i is ignored outside REQ: no state change, no counter change.
- wbm_we_o, wbm_adr_o, wbm_dat_o and wbm_sel_o hold their last values after cyc drops.
- txn_cnt wraps modulo 2^CNTW.

Decomposition:
- Shared package neuro_wb_pkg holds:
  - state enum: IDLE, REQ, RESP
  - NEURO_WB_BASE = 32'h3000_0000
  - default AW and DW
  - TIMEOUT default
- The timer and TIMEOUT compare go in one small sub-module, neuro_wb_timeout. Its ports are clr, en and expired, and its width is $clog2(TIMEOUT+1).
- The FSM and counters stay in the top module.

Test Plan:
- Write, slave acks 3 cycles after stb:
  - Stimulus: adr 0x3000_0004, dat 0xDEAD_BEEF, sel 0xF.
  - Required: the wbm_* lines carry those values while cyc = stb = 1 for exactly 3 cycles; rsp_valid follows with err = 0, dat = 0; txn_cnt = 1.
- Read, combinational ack in the first stb cycle:
  - Stimulus: slave returns 0x1234_5678.
  - Required: rsp_valid 2 cycles after the command handshake, rsp_dat = 0x1234_5678.
- Timeout, TIMEOUT = 8, slave never acks:
  - Required: stb high for exactly 8 cycles, then rsp_err = 1, rsp_dat = 0, err_cnt = 1.
- Ack in the timeout cycle:
  - Stimulus: ack exactly at timer == 7.
  - Required: rsp_err = 0, err_cnt unchanged.
- Response backpressure:
  - Stimulus: rsp_ready held 0 for 5 cycles while cmd_valid stays 1.
  - Required: rsp is held stable, cmd_ready = 0 throughout, and the next command is accepted the cycle after the rsp handshake.
- Reset mid-REQ:
  - Stimulus: assert wb_rst_n = 0 while stb is high.
  - Required: cyc, stb and rsp_valid are 0 asynchronously; after release the block is in IDLE with cmd_ready = 1 and both counters = 0.
